// File: rtl/snake_dir_scheduler.sv
// -----------------------------------------------------------------------------
// snake_dir_scheduler
//
// Turns debounced direction-button pulses into snake heading changes.
// Simultaneous presses are arbitrated (up > down > left > right), the winner
// is buffered in a small FIFO, and at most one buffered request is applied
// per game tick. A pause toggle freezes the heading and flushes the FIFO.
//
// Optional feature macro: REVERSE_REJECT_EN
//   defined   -> a popped request that is the exact opposite of the current
//                heading is discarded and signalled on 'reject'.
//   undefined -> every popped request is applied; 'reject' stays 0.
//
// Ports
//   clk        in   1           system clock, posedge
//   reset_n    in   1           synchronous active-low reset
//   btn_pulse  in   4           debounced pulses: bit0 up, bit1 down,
//                               bit2 left, bit3 right
//   pause_req  in   1           pulse, toggles RUN/PAUSED
//   tick       in   1           game step strobe
//   dir        out  2           current heading (00 up, 01 down, 10 left,
//                               11 right)
//   dir_valid  out  1           pulse: dir was loaded from the FIFO
//   reject     out  1           pulse: popped request discarded as reversal
//   drop       out  1           pulse: request lost to collision / full FIFO
//   q_count    out  PTR_BITS+1  FIFO occupancy
//   paused     out  1           high while PAUSED
// -----------------------------------------------------------------------------
module snake_dir_scheduler #(
   parameter int         QUEUE_DEPTH = 4,
   parameter int         PTR_BITS    = 2,
   parameter logic [1:0] INIT_DIR    = 2'b11
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [3:0]          btn_pulse,
   input  logic                pause_req,
   input  logic                tick,
   output logic [1:0]          dir,
   output logic                dir_valid,
   output logic                reject,
   output logic                drop,
   output logic [PTR_BITS:0]   q_count,
   output logic                paused
);

   localparam logic [PTR_BITS:0]   DEPTH_C   = (PTR_BITS+1)'(QUEUE_DEPTH);
   localparam logic [PTR_BITS:0]   CNT_ONE_C = (PTR_BITS+1)'(1);
   localparam logic [PTR_BITS-1:0] PTR_ONE_C = PTR_BITS'(1);

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_PAUSED = 1'b1
   } state_t;

`ifdef REVERSE_REJECT_EN
   // Opposite headings share the axis bit [1] and differ in the sense bit [0].
   function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
      return (a[1] == b[1]) && (a[0] != b[0]);
   endfunction
`endif

   // Registered state
   state_t              state_r;
   logic                paused_r;
   logic [1:0]          fifo_mem_r [QUEUE_DEPTH];
   logic [PTR_BITS-1:0] head_r;
   logic [PTR_BITS-1:0] tail_r;
   logic [PTR_BITS:0]   count_r;
   logic [1:0]          dir_r;
   logic                dir_valid_r;
   logic                reject_r;
   logic                drop_r;

   // Combinational decisions for the current cycle
   logic [1:0]          win_dir_s;
   logic                win_valid_s;
   logic                multi_s;
   logic                run_s;
   logic                full_s;
   logic                pop_s;
   logic                flush_s;
   logic                push_s;
   logic [1:0]          head_dir_s;
   logic                reject_s;
   logic                drop_s;

   // Fixed-priority arbitration of the button pulses.
   always_comb begin
      win_dir_s   = 2'b00;
      win_valid_s = 1'b1;
      if (btn_pulse[0]) begin
         win_dir_s = 2'b00;
      end else if (btn_pulse[1]) begin
         win_dir_s = 2'b01;
      end else if (btn_pulse[2]) begin
         win_dir_s = 2'b10;
      end else if (btn_pulse[3]) begin
         win_dir_s = 2'b11;
      end else begin
         win_dir_s   = 2'b00;
         win_valid_s = 1'b0;
      end
   end

   // Clearing the lowest set bit leaves a nonzero value only if two or more
   // buttons fired together.
   assign multi_s = ((btn_pulse & (btn_pulse - 4'd1)) != 4'd0);

   // Pop/push/flush qualification and pulse causes.
   always_comb begin
      run_s      = (state_r == ST_RUN);
      full_s     = (count_r == DEPTH_C);
      pop_s      = run_s && tick && (count_r != '0);
      // Entering PAUSED flushes the FIFO; a same-cycle enqueue is swallowed
      // silently rather than reported as a drop.
      flush_s    = run_s && pause_req;
      push_s     = win_valid_s && !flush_s && (!full_s || pop_s);
      head_dir_s = fifo_mem_r[head_r];
`ifdef REVERSE_REJECT_EN
      reject_s   = pop_s && is_opposite(head_dir_s, dir_r);
`else
      reject_s   = 1'b0;
`endif
      drop_s     = multi_s || (win_valid_s && !flush_s && full_s && !pop_s);
   end

   // RUN/PAUSED state machine with registered paused flag.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r  <= ST_RUN;
         paused_r <= 1'b0;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (pause_req) begin
                  state_r  <= ST_PAUSED;
                  paused_r <= 1'b1;
               end
            end
            ST_PAUSED: begin
               if (pause_req) begin
                  state_r  <= ST_RUN;
                  paused_r <= 1'b0;
               end
            end
            default: begin
               state_r  <= ST_RUN;
               paused_r <= 1'b0;
            end
         endcase
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at QUEUE_DEPTH.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else if (flush_s) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else begin
         if (push_s) begin
            tail_r <= tail_r + PTR_ONE_C;
         end
         if (pop_s) begin
            head_r <= head_r + PTR_ONE_C;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE_C;
            2'b01:   count_r <= count_r - CNT_ONE_C;
            default: count_r <= count_r;
         endcase
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem_r[tail_r] <= win_dir_s;
      end
   end

   // Heading register and single-cycle event pulses.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dir_r       <= INIT_DIR;
         dir_valid_r <= 1'b0;
         reject_r    <= 1'b0;
         drop_r      <= 1'b0;
      end else begin
         dir_valid_r <= pop_s && !reject_s;
         reject_r    <= reject_s;
         drop_r      <= drop_s;
         if (pop_s && !reject_s) begin
            dir_r <= head_dir_s;
         end
      end
   end

   assign dir       = dir_r;
   assign dir_valid = dir_valid_r;
   assign reject    = reject_r;
   assign drop      = drop_r;
   assign q_count   = count_r;
   assign paused    = paused_r;

endmodule
